move_list_drain: RTL and testbench

//  Board-level reader for the per-column move FIFOs filled by the eight column units.
//  - After each column raises done, drains that column's FIFO word by word.
//  - A FIFO word is SLOTS packed moves; each word is unpacked into a stream of single moves.
//  - The move stream goes to the search/eval stage over a valid/ready handshake.
//  - Move format is [18:12] flags {invalid,promote,pawn,pawn2,ep,castle,capture}, [11:6] from, [5:0] to.

---
 rtl/move_list_drain.sv | 197 +++++++++++++++++++
 tb/tb_move_list_drain.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_list_drain.sv
// Drains the per-column move FIFOs after each column unit finishes and streams single moves out.
// Define MOVE_STATS_EN to add the capture_count output.
module move_list_drain #(
    parameter int unsigned NCOL  = 8,
    parameter int unsigned SLOTS = 8,
    parameter int unsigned MW    = 19,
    parameter int unsigned CNTW  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NCOL-1:0]         col_done,
    output logic [NCOL-1:0]         col_rden,
    input  logic [NCOL*SLOTS*MW-1:0] col_rdata,
    output logic                    mv_valid,
    input  logic                    mv_ready,
    output logic [MW-1:0]           mv_data,
    output logic                    busy,
    output logic                    done,
    output logic [CNTW-1:0]         move_count,
    output logic                    overflow
`ifdef MOVE_STATS_EN
    ,
    output logic [CNTW-1:0]         capture_count
`endif
);

    localparam int unsigned WW      = SLOTS * MW;
    localparam int unsigned PW      = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int unsigned SW      = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned INV_BIT = MW - 1;
    localparam int unsigned CAP_BIT = MW - 7;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StRead,
        StLatch,
        StEmit,
        StDone
    } state_e;

    state_e            state_q;
    logic [PW-1:0]     ptr_q;
    logic [SW-1:0]     slot_q;
    logic [NCOL-1:0]   drained_q;
    logic [WW-1:0]     word_q;
    logic [NCOL-1:0]   col_rden_q;
    logic              mv_valid_q;
    logic [MW-1:0]     mv_data_q;
    logic              busy_q;
    logic              done_q;
    logic [CNTW-1:0]   move_count_q;
    logic              overflow_q;
`ifdef MOVE_STATS_EN
    logic [CNTW-1:0]   capture_count_q;
`endif

    logic              scan_hit;
    logic [PW-1:0]     scan_idx;
    logic [WW-1:0]     rd_word;
    logic              rd_end;
    logic [SW-1:0]     slot_nxt;
    logic [MW-1:0]     nxt_move;
    logic              last_slot;

    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        // Downward walk so the lowest eligible column wins.
        for (int c = int'(NCOL) - 1; c >= 0; c--) begin
            if (col_done[c] && !drained_q[c]) begin
                scan_hit = 1'b1;
                scan_idx = PW'(c);
            end
        end
        rd_word = col_rdata[int'(ptr_q) * WW +: WW];
        rd_end  = 1'b1;
        for (int s = 0; s < int'(SLOTS); s++) begin
            rd_end = rd_end & rd_word[s * MW + INV_BIT];
        end
        slot_nxt  = slot_q + SW'(1);
        nxt_move  = word_q[int'(slot_nxt) * MW +: MW];
        last_slot = (slot_q == SW'(SLOTS - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            ptr_q           <= '0;
            slot_q          <= '0;
            drained_q       <= '0;
            word_q          <= '0;
            col_rden_q      <= '0;
            mv_valid_q      <= 1'b0;
            mv_data_q       <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            move_count_q    <= '0;
            overflow_q      <= 1'b0;
`ifdef MOVE_STATS_EN
            capture_count_q <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q         <= StScan;
                        drained_q       <= '0;
                        move_count_q    <= '0;
                        overflow_q      <= 1'b0;
                        busy_q          <= 1'b1;
                        done_q          <= 1'b0;
`ifdef MOVE_STATS_EN
                        capture_count_q <= '0;
`endif
                    end
                end
                StScan: begin
                    if (&drained_q) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (scan_hit) begin
                        ptr_q      <= scan_idx;
                        col_rden_q <= NCOL'(1) << scan_idx;
                        state_q    <= StRead;
                    end
                end
                StRead: begin
                    col_rden_q <= '0;
                    state_q    <= StLatch;
                end
                StLatch: begin
                    word_q <= rd_word;
                    slot_q <= '0;
                    if (rd_end) begin
                        drained_q[ptr_q] <= 1'b1;
                        state_q          <= StScan;
                    end else begin
                        state_q    <= StEmit;
                        mv_valid_q <= !rd_word[INV_BIT];
                        if (!rd_word[INV_BIT]) begin
                            mv_data_q <= rd_word[MW-1:0];
                        end
                    end
                end
                StEmit: begin
                    // Advance on a handshake, or straight away when the slot is being skipped.
                    if (!mv_valid_q || mv_ready) begin
                        if (mv_valid_q) begin
                            if (&move_count_q) begin
                                overflow_q <= 1'b1;
                            end else begin
                                move_count_q <= move_count_q + CNTW'(1);
                            end
`ifdef MOVE_STATS_EN
                            if (mv_data_q[CAP_BIT] && !(&capture_count_q)) begin
                                capture_count_q <= capture_count_q + CNTW'(1);
                            end
`endif
                        end
                        if (last_slot) begin
                            mv_valid_q <= 1'b0;
                            col_rden_q <= NCOL'(1) << ptr_q;
                            state_q    <= StRead;
                        end else begin
                            slot_q     <= slot_nxt;
                            mv_valid_q <= !nxt_move[INV_BIT];
                            if (!nxt_move[INV_BIT]) begin
                                mv_data_q <= nxt_move;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign col_rden   = col_rden_q;
    assign mv_valid   = mv_valid_q;
    assign mv_data    = mv_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign move_count = move_count_q;
    assign overflow   = overflow_q;
`ifdef MOVE_STATS_EN
    assign capture_count = capture_count_q;
`else
    logic unused_cap;
    assign unused_cap = ^{word_q[CAP_BIT], mv_data_q[CAP_BIT]};
`endif

endmodule

// File: tb/tb_move_list_drain.sv
// Directed self-checking bench for move_list_drain with a queue-based FIFO model per column.
module tb_move_list_drain;
    localparam int NCOL  = 8;
    localparam int SLOTS = 8;
    localparam int MW    = 19;
    localparam int CNTW  = 8;
    localparam int WW    = SLOTS * MW;

    typedef logic [WW-1:0] word_t;
    typedef logic [MW-1:0] mv_t;

    logic                clk;
    logic                reset;
    logic                start;
    logic [NCOL-1:0]     col_done;
    logic [NCOL-1:0]     col_rden;
    logic [NCOL*WW-1:0]  col_rdata;
    logic                mv_valid;
    logic                mv_ready;
    logic [MW-1:0]       mv_data;
    logic                busy;
    logic                done;
    logic [CNTW-1:0]     move_count;
    logic                overflow;
`ifdef MOVE_STATS_EN
    logic [CNTW-1:0]     capture_count;
`endif

    word_t fifo [NCOL][$];
    mv_t   hs_q[$];
    mv_t   exp_q[$];
    int    rden_log[$];
    int    onehot_err;
    int    checks;
    int    failures;

    move_list_drain #(
        .NCOL (NCOL),
        .SLOTS(SLOTS),
        .MW   (MW),
        .CNTW (CNTW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .col_done  (col_done),
        .col_rden  (col_rden),
        .col_rdata (col_rdata),
        .mv_valid  (mv_valid),
        .mv_ready  (mv_ready),
        .mv_data   (mv_data),
        .busy      (busy),
        .done      (done),
        .move_count(move_count),
        .overflow  (overflow)
`ifdef MOVE_STATS_EN
        ,
        .capture_count(capture_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mv_t mk(input logic [6:0] fl, input logic [5:0] fr, input logic [5:0] to);
        return {fl, fr, to};
    endfunction

    function automatic word_t end_word();
        word_t w;
        for (int s = 0; s < SLOTS; s++) w[s*MW +: MW] = 19'h40000;
        return w;
    endfunction

    // FIFO model: a read enable returns the next word on the following cycle.
    always @(posedge clk) begin
        if (mv_valid && mv_ready) hs_q.push_back(mv_data);
        if ($countones(col_rden) > 1) onehot_err++;
        for (int c = 0; c < NCOL; c++) begin
            if (col_rden[c]) begin
                rden_log.push_back(c);
                if (fifo[c].size() > 0) col_rdata[c*WW +: WW] <= fifo[c].pop_front();
                else col_rdata[c*WW +: WW] <= end_word();
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        for (int c = 0; c < NCOL; c++) fifo[c].delete();
        hs_q.delete();
        rden_log.delete();
    endtask

    task automatic finish_fifos();
        for (int c = 0; c < NCOL; c++) fifo[c].push_back(end_word());
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!mv_valid && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        word_t w;
        int    idx;
        int    n0;
        int    mism;
        checks     = 0;
        failures   = 0;
        onehot_err = 0;
        reset      = 1'b1;
        start      = 1'b0;
        col_done   = '0;
        mv_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(mv_valid), 32'd0);
        check_eq("rst_rden", 32'(col_rden), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_count", 32'(move_count), 32'd0);
        reset = 1'b0;

        // 1: column 0 holds e2e4, e2e3; every other column is empty.
        clear_all();
        w = end_word();
        w[0 +: MW]  = mk(7'h00, 6'd12, 6'd28);
        w[MW +: MW] = mk(7'h00, 6'd12, 6'd20);
        fifo[0].push_back(w);
        finish_fifos();
        col_done = '1;
        mv_ready = 1'b1;
        pulse_start();
        check_eq("t1_busy", 32'(busy), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t1_lat_valid", 32'(mv_valid), 32'd1);
        check_eq("t1_lat_data", 32'(mv_data), 32'(mk(7'h00, 6'd12, 6'd28)));
        wait_done("t1_done", 200);
        check_eq("t1_nmoves", hs_q.size(), 32'd2);
        check_eq("t1_mv0", 32'(hs_q[0]), 32'(mk(7'h00, 6'd12, 6'd28)));
        check_eq("t1_mv1", 32'(hs_q[1]), 32'(mk(7'h00, 6'd12, 6'd20)));
        check_eq("t1_count", 32'(move_count), 32'd2);
        check_eq("t1_busy_end", 32'(busy), 32'd0);
        check_eq("t1_nreads", rden_log.size(), 32'd9);
        check_eq("t1_read1", rden_log[1], 32'd0);
        check_eq("t1_read8", rden_log[8], 32'd7);

        // 2: columns 2 and 5 go done together; column 2 drains first.
        clear_all();
        w = end_word();
        w[0 +: MW] = mk(7'h01, 6'd1, 6'd2);
        fifo[2].push_back(w);
        w = end_word();
        w[3*MW +: MW] = mk(7'h00, 6'd3, 6'd4);
        fifo[5].push_back(w);
        finish_fifos();
        col_done = '0;
        pulse_start();
        col_done = 8'b0010_0100;
        n0 = 0;
        while (rden_log.size() < 4 && n0 < 100) begin
            @(posedge clk);
            #1;
            n0++;
        end
        check_eq("t2_nreads", rden_log.size(), 32'd4);
        check_eq("t2_read0", rden_log[0], 32'd2);
        check_eq("t2_read1", rden_log[1], 32'd2);
        check_eq("t2_read2", rden_log[2], 32'd5);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t2_scan_busy", 32'(busy), 32'd1);
        col_done = '1;
        wait_done("t2_done", 200);
        check_eq("t2_mv0", 32'(hs_q[0]), 32'(mk(7'h01, 6'd1, 6'd2)));
        check_eq("t2_mv1", 32'(hs_q[1]), 32'(mk(7'h00, 6'd3, 6'd4)));
        check_eq("t2_count", 32'(move_count), 32'd2);

        // 3: back-pressure holds the move steady and stops FIFO reads.
        clear_all();
        w = end_word();
        w[0 +: MW] = mk(7'h02, 6'd10, 6'd11);
        fifo[0].push_back(w);
        finish_fifos();
        mv_ready = 1'b0;
        pulse_start();
        wait_valid(20);
        n0 = rden_log.size();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check_eq("t3_hold_valid", 32'(mv_valid), 32'd1);
            check_eq("t3_hold_data", 32'(mv_data), 32'(mk(7'h02, 6'd10, 6'd11)));
        end
        check_eq("t3_no_reads", rden_log.size(), n0);
        mv_ready = 1'b1;
        wait_done("t3_done", 200);
        check_eq("t3_nmoves", hs_q.size(), 32'd1);

        // 4: 260 moves saturate the counter; column 4 word has skipped slots.
        clear_all();
        exp_q.delete();
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 8; k++) begin
                for (int s = 0; s < SLOTS; s++) begin
                    w[s*MW +: MW] = mv_t'(idx);
                    exp_q.push_back(mv_t'(idx));
                    idx++;
                end
                fifo[c].push_back(w);
            end
        end
        w = end_word();
        for (int s = 0; s < SLOTS; s++) begin
            if (s == 0 || s == 2 || s == 5 || s == 7) begin
                w[s*MW +: MW] = mv_t'(idx);
                exp_q.push_back(mv_t'(idx));
                idx++;
            end
        end
        fifo[4].push_back(w);
        finish_fifos();
        pulse_start();
        wait_done("t4_done", 2000);
        check_eq("t4_nmoves", hs_q.size(), 32'd260);
        mism = 0;
        for (int i = 0; i < 260; i++) if (hs_q[i] !== exp_q[i]) mism++;
        check_eq("t4_order", mism, 32'd0);
        check_eq("t4_count", 32'(move_count), 32'd255);
        check_eq("t4_overflow", 32'(overflow), 32'd1);

        // 5: reset while column 3 is presenting slot 4.
        clear_all();
        for (int s = 0; s < SLOTS; s++) w[s*MW +: MW] = mk(7'h00, 6'd3, 6'(s));
        fifo[3].push_back(w);
        finish_fifos();
        mv_ready = 1'b0;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            wait_valid(50);
            mv_ready = 1'b1;
            @(posedge clk);
            #1 mv_ready = 1'b0;
        end
        wait_valid(50);
        check_eq("t5_slot4", 32'(mv_data), 32'(mk(7'h00, 6'd3, 6'd4)));
        check_eq("t5_count", 32'(move_count), 32'd4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t5_valid", 32'(mv_valid), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_rcount", 32'(move_count), 32'd0);
        check_eq("t5_rden", 32'(col_rden), 32'd0);
        reset = 1'b0;

`ifdef MOVE_STATS_EN
        // 6: three captures among five moves.
        clear_all();
        w = end_word();
        w[0 +: MW]    = mk(7'h01, 6'd0, 6'd1);
        w[MW +: MW]   = mk(7'h00, 6'd0, 6'd2);
        w[2*MW +: MW] = mk(7'h01, 6'd0, 6'd3);
        w[3*MW +: MW] = mk(7'h00, 6'd0, 6'd4);
        w[4*MW +: MW] = mk(7'h01, 6'd0, 6'd5);
        fifo[0].push_back(w);
        finish_fifos();
        mv_ready = 1'b1;
        pulse_start();
        wait_done("t6_done", 200);
        check_eq("t6_capture", 32'(capture_count), 32'd3);
        check_eq("t6_count", 32'(move_count), 32'd5);
`endif

        check_eq("rden_onehot", onehot_err, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
